// File: rtl/udp_stream_probe_tap.sv
// Passive probe on a 32-bit UDP payload stream: taps recent beats, tracks framing,
// byte lengths, stalls and handshake violations, and exports everything as registered probes.
module udp_stream_probe_tap #(
  parameter int unsigned MAX_WORDS = 376,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_ready,
  input  logic        s_last,
  input  logic [3:0]  s_keep,
  output logic [32:0] tap0,
  output logic [32:0] tap1,
  output logic [32:0] tap2,
  output logic        sop_p,
  output logic        eop_p,
  output logic        err_len_p,
  output logic        err_stall_p,
  output logic        err_proto_p,
  output logic [31:0] pkt_cnt,
  output logic        pkt_active,
  output logic [95:0] hist_head,
  output logic [95:0] hist_tail,
  output logic [95:0] stat_word
);

  localparam int unsigned IW = $clog2(MAX_WORDS + 2);
  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_IN_PKT, ST_DRAIN} state_t;

  state_t      r_state, w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_idle;
  logic [31:0] r_bytes;
  logic [63:0] r_win;
  logic        r_hold, r_hold_last;
  logic [31:0] r_hold_data;

  logic [32:0] r_tap0, r_tap1, r_tap2;
  logic        r_sop, r_eop, r_err_len, r_err_stall, r_err_proto, r_pkt_active;
  logic [31:0] r_pkt_cnt, r_err_cnt, r_last_bytes, r_max_bytes;
  logic [95:0] r_hist_head, r_hist_tail;

  logic        w_beat, w_stall_hit;
  logic        w_sop, w_eop, w_err_len, w_err_stall, w_err_proto;
  logic [2:0]  w_pop, w_beat_bytes;
  logic [31:0] w_total;
  logic [95:0] w_win_nxt;
  logic [1:0]  w_err_inc;
  logic [32:0] w_err_sum;

  assign w_beat      = s_valid & s_ready;
  assign w_stall_hit = (r_idle == CW'(TIMEOUT - 1));
  assign w_pop       = 3'(s_keep[0]) + 3'(s_keep[1]) + 3'(s_keep[2]) + 3'(s_keep[3]);
  // Only the last beat is partial; an empty keep on it still means a full word.
  assign w_beat_bytes = (s_last && (s_keep != 4'd0)) ? w_pop : 3'd4;
  assign w_total     = (r_state == ST_IDLE) ? 32'(w_beat_bytes) : r_bytes + 32'(w_beat_bytes);
  assign w_win_nxt   = (r_state == ST_IDLE) ? {64'd0, s_data} : {r_win, s_data};
  assign w_err_proto = r_hold & (~s_valid | (s_data != r_hold_data) | (s_last != r_hold_last));
  assign w_err_inc   = 2'(w_err_len) + 2'(w_err_stall) + 2'(w_err_proto);
  assign w_err_sum   = {1'b0, r_err_cnt} + 33'(w_err_inc);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and framing events
  always_comb begin
    w_state_nxt = r_state;
    w_sop       = 1'b0;
    w_eop       = 1'b0;
    w_err_len   = 1'b0;
    w_err_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_beat) begin
          w_sop = 1'b1;
          if (s_last) w_eop = 1'b1;
          else        w_state_nxt = ST_IN_PKT;
        end
      end
      ST_IN_PKT: begin
        if (w_beat) begin
          if (r_idx >= IW'(MAX_WORDS)) begin
            w_err_len   = 1'b1;
            w_state_nxt = s_last ? ST_IDLE : ST_DRAIN;
          end else if (s_last) begin
            w_eop       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_stall_hit) begin
          w_err_stall = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (w_beat) begin
          if (s_last) w_state_nxt = ST_IDLE;
        end else if (w_stall_hit) begin
          w_err_stall = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath, counters and probe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_idle       <= '0;
      r_bytes      <= '0;
      r_win        <= '0;
      r_hold       <= 1'b0;
      r_hold_last  <= 1'b0;
      r_hold_data  <= '0;
      r_tap0       <= '0;
      r_tap1       <= '0;
      r_tap2       <= '0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
      r_err_len    <= 1'b0;
      r_err_stall  <= 1'b0;
      r_err_proto  <= 1'b0;
      r_pkt_active <= 1'b0;
      r_pkt_cnt    <= '0;
      r_err_cnt    <= '0;
      r_last_bytes <= '0;
      r_max_bytes  <= '0;
      r_hist_head  <= '0;
      r_hist_tail  <= '0;
    end else begin
      r_sop        <= w_sop;
      r_eop        <= w_eop;
      r_err_len    <= w_err_len;
      r_err_stall  <= w_err_stall;
      r_err_proto  <= w_err_proto;
      r_pkt_active <= (w_state_nxt != ST_IDLE);
      r_hold       <= s_valid & ~s_ready;
      r_hold_data  <= s_data;
      r_hold_last  <= s_last;
      r_err_cnt    <= w_err_sum[32] ? 32'hFFFF_FFFF : w_err_sum[31:0];

      if (w_beat || r_state == ST_IDLE || w_err_stall) r_idle <= '0;
      else                                             r_idle <= r_idle + CW'(1);

      if (w_beat) begin
        r_tap2 <= r_tap1;
        r_tap1 <= r_tap0;
        r_tap0 <= {s_last, s_data};
        if (r_state == ST_IDLE) begin
          r_idx       <= IW'(1);
          r_bytes     <= w_total;
          r_win       <= w_win_nxt[63:0];
          r_hist_head <= {s_data, 64'd0};
        end else if (r_state == ST_IN_PKT) begin
          r_idx   <= r_idx + IW'(1);
          r_bytes <= w_total;
          r_win   <= w_win_nxt[63:0];
          if (r_idx == IW'(1)) r_hist_head[63:32] <= s_data;
          if (r_idx == IW'(2)) r_hist_head[31:0]  <= s_data;
        end
      end

      if (w_eop) begin
        r_hist_tail  <= w_win_nxt;
        r_last_bytes <= w_total;
        r_max_bytes  <= (w_total > r_max_bytes) ? w_total : r_max_bytes;
        if (r_pkt_cnt != 32'hFFFF_FFFF) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
    end
  end

  assign tap0        = r_tap0;
  assign tap1        = r_tap1;
  assign tap2        = r_tap2;
  assign sop_p       = r_sop;
  assign eop_p       = r_eop;
  assign err_len_p   = r_err_len;
  assign err_stall_p = r_err_stall;
  assign err_proto_p = r_err_proto;
  assign pkt_cnt     = r_pkt_cnt;
  assign pkt_active  = r_pkt_active;
  assign hist_head   = r_hist_head;
  assign hist_tail   = r_hist_tail;
  assign stat_word   = {r_last_bytes, r_err_cnt, r_max_bytes};

endmodule

// File: tb/tb_udp_stream_probe_tap.sv
// Directed self-checking bench for udp_stream_probe_tap.
module tb_udp_stream_probe_tap;

  localparam int unsigned MAX_WORDS = 376;
  localparam int unsigned TIMEOUT   = 1024;

  logic        clk, rst_n;
  logic [31:0] s_data;
  logic        s_valid, s_ready, s_last;
  logic [3:0]  s_keep;
  logic [32:0] tap0, tap1, tap2;
  logic        sop_p, eop_p, err_len_p, err_stall_p, err_proto_p, pkt_active;
  logic [31:0] pkt_cnt;
  logic [95:0] hist_head, hist_tail, stat_word;

  int n_checks;
  int n_fail;

  udp_stream_probe_tap #(.MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .s_keep(s_keep), .tap0(tap0), .tap1(tap1), .tap2(tap2),
    .sop_p(sop_p), .eop_p(eop_p), .err_len_p(err_len_p), .err_stall_p(err_stall_p),
    .err_proto_p(err_proto_p), .pkt_cnt(pkt_cnt), .pkt_active(pkt_active),
    .hist_head(hist_head), .hist_tail(hist_tail), .stat_word(stat_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus; returns 1 time unit after the capturing edge.
  task automatic drive(input logic v, input logic r, input logic [31:0] d,
                       input logic l, input logic [3:0] k);
    s_valid = v;
    s_ready = r;
    s_data  = d;
    s_last  = l;
    s_keep  = k;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_ready = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    s_keep  = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic seen_eop;
  int   first_k;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    do_reset();

    chk("rst_tap0",   96'(tap0), 96'(0));
    chk("rst_pktcnt", 96'(pkt_cnt), 96'(0));
    chk("rst_stat",   stat_word, 96'(0));
    chk("rst_head",   hist_head, 96'(0));
    chk("rst_active", 96'(pkt_active), 96'(0));

    // 4-beat packet, last keep 1100
    drive(1, 1, 32'h11111111, 0, 4'hF);
    chk("p4_sop", 96'(sop_p), 96'(1));
    chk("p4_active", 96'(pkt_active), 96'(1));
    drive(1, 1, 32'h22222222, 0, 4'hF);
    chk("p4_sop_end", 96'(sop_p), 96'(0));
    drive(1, 1, 32'h33333333, 0, 4'hF);
    drive(1, 1, 32'h44444444, 1, 4'b1100);
    chk("p4_eop",    96'(eop_p), 96'(1));
    chk("p4_pktcnt", 96'(pkt_cnt), 96'(1));
    chk("p4_bytes",  96'(stat_word[95:64]), 96'(14));
    chk("p4_max",    96'(stat_word[31:0]), 96'(14));
    chk("p4_head",   hist_head, {32'h11111111, 32'h22222222, 32'h33333333});
    chk("p4_tail",   hist_tail, {32'h22222222, 32'h33333333, 32'h44444444});
    chk("p4_tap0",   96'(tap0), 96'({1'b1, 32'h44444444}));
    chk("p4_tap1",   96'(tap1), 96'({1'b0, 32'h33333333}));
    chk("p4_tap2",   96'(tap2), 96'({1'b0, 32'h22222222}));
    chk("p4_idle",   96'(pkt_active), 96'(0));
    drive(0, 1, 32'h0, 0, 4'h0);
    chk("p4_eop_end", 96'(eop_p), 96'(0));

    // Single-beat packet
    drive(1, 1, 32'hDEADBEEF, 1, 4'hF);
    chk("p1_sop",    96'(sop_p), 96'(1));
    chk("p1_eop",    96'(eop_p), 96'(1));
    chk("p1_idle",   96'(pkt_active), 96'(0));
    chk("p1_head",   hist_head, {32'hDEADBEEF, 64'd0});
    chk("p1_tail",   hist_tail, {64'd0, 32'hDEADBEEF});
    chk("p1_bytes",  96'(stat_word[95:64]), 96'(4));
    chk("p1_max",    96'(stat_word[31:0]), 96'(14));
    chk("p1_pktcnt", 96'(pkt_cnt), 96'(2));

    // Oversize packet: 380 beats, error on beat 377
    do_reset();
    seen_eop = 1'b0;
    for (int i = 1; i <= 380; i++) begin
      drive(1, 1, 32'(i), (i == 380), 4'hF);
      if (eop_p) seen_eop = 1'b1;
      if (i == 376) chk("len_376_ok", 96'(err_len_p), 96'(0));
      if (i == 377) begin
        chk("len_377_err", 96'(err_len_p), 96'(1));
        chk("len_drain",   96'(pkt_active), 96'(1));
      end
    end
    chk("len_no_eop", 96'(seen_eop), 96'(0));
    chk("len_errcnt", 96'(stat_word[63:32]), 96'(1));
    chk("len_pktcnt", 96'(pkt_cnt), 96'(0));
    chk("len_idle",   96'(pkt_active), 96'(0));

    // Maximum legal packet: exactly MAX_WORDS beats
    for (int i = 1; i <= 376; i++) drive(1, 1, 32'h1000 + 32'(i), (i == 376), 4'hF);
    chk("max_eop",    96'(eop_p), 96'(1));
    chk("max_noerr",  96'(err_len_p), 96'(0));
    chk("max_pktcnt", 96'(pkt_cnt), 96'(1));
    chk("max_bytes",  96'(stat_word[95:64]), 96'(1504));
    chk("max_max",    96'(stat_word[31:0]), 96'(1504));
    chk("max_tail",   hist_tail, {32'h1176, 32'h1177, 32'h1178});

    // Stall: two beats then silence
    do_reset();
    drive(1, 1, 32'hC0DE0001, 0, 4'hF);
    drive(1, 1, 32'hC0DE0002, 0, 4'hF);
    first_k = 0;
    for (int k = 1; k <= int'(TIMEOUT) + 8; k++) begin
      drive(0, 1, 32'h0, 0, 4'h0);
      if (err_stall_p && first_k == 0) first_k = k;
    end
    chk("stall_at",     96'(first_k), 96'(TIMEOUT));
    chk("stall_idle",   96'(pkt_active), 96'(0));
    chk("stall_errcnt", 96'(stat_word[63:32]), 96'(1));
    chk("stall_pktcnt", 96'(pkt_cnt), 96'(0));
    chk("stall_tail",   hist_tail, 96'(0));
    drive(1, 1, 32'hAAAA0001, 0, 4'hF);
    chk("stall_sop", 96'(sop_p), 96'(1));
    drive(1, 1, 32'hAAAA0002, 1, 4'b1000);
    chk("stall_eop",    96'(eop_p), 96'(1));
    chk("stall_pkt2",   96'(pkt_cnt), 96'(1));
    chk("stall_bytes",  96'(stat_word[95:64]), 96'(5));
    chk("stall_tail2",  hist_tail, {32'd0, 32'hAAAA0001, 32'hAAAA0002});

    // Handshake violation: data changes while stalled
    do_reset();
    drive(1, 0, 32'hA5A5A5A5, 0, 4'hF);
    chk("proto_none", 96'(err_proto_p), 96'(0));
    drive(1, 0, 32'h5A5A5A5A, 0, 4'hF);
    chk("proto_err",    96'(err_proto_p), 96'(1));
    chk("proto_errcnt", 96'(stat_word[63:32]), 96'(1));
    chk("proto_tap0",   96'(tap0), 96'(0));
    drive(1, 0, 32'h5A5A5A5A, 0, 4'hF);
    chk("proto_pulse",   96'(err_proto_p), 96'(0));
    chk("proto_errcnt2", 96'(stat_word[63:32]), 96'(1));
    drive(1, 1, 32'h5A5A5A5A, 1, 4'hF);
    chk("proto_tap_beat", 96'(tap0), 96'({1'b1, 32'h5A5A5A5A}));
    chk("proto_pktcnt",   96'(pkt_cnt), 96'(1));
    drive(0, 1, 32'h0, 0, 4'h0);
    chk("proto_quiet", 96'(err_proto_p), 96'(0));

    // Reset mid-packet (beat 3 of 10)
    do_reset();
    for (int i = 1; i <= 3; i++) drive(1, 1, 32'h100 + 32'(i), 0, 4'hF);
    chk("mid_active_pre", 96'(pkt_active), 96'(1));
    rst_n = 1'b0;
    #2;
    chk("mid_tap0",   96'(tap0), 96'(0));
    chk("mid_active", 96'(pkt_active), 96'(0));
    chk("mid_head",   hist_head, 96'(0));
    chk("mid_stat",   stat_word, 96'(0));
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 1, 32'h200, 0, 4'hF);
    chk("mid_sop", 96'(sop_p), 96'(1));
    drive(1, 1, 32'h201, 1, 4'hF);
    chk("mid_eop",    96'(eop_p), 96'(1));
    chk("mid_pktcnt", 96'(pkt_cnt), 96'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
